// File: rtl/spu32_cpu_mul_radix.sv
// Iterative radix-2^BITS_PER_CYCLE shift-add multiplier for the SPU32 CPU.
// Retires BITS_PER_CYCLE multiplier bits per clock and stops as soon as the shifted multiplier reaches zero.
module spu32_cpu_mul_radix #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic               I_clk,
    input  logic               I_reset_n,
    input  logic               I_en,
    input  logic [WIDTH-1:0]   I_s1,
    input  logic [WIDTH-1:0]   I_s2,
    input  logic               I_s1_signed,
    input  logic               I_s2_signed,
    input  logic               I_hi,
    output logic [WIDTH-1:0]   O_result,
    output logic [2*WIDTH-1:0] O_product,
    output logic               O_busy,
    output logic               O_done
);

    localparam int PW = 2 * WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] acc;
    logic [PW-1:0] acc_next;
    logic [PW-1:0] s1;
    logic [PW-1:0] s1_next;
    logic [PW-1:0] s2;
    logic [PW-1:0] s2_next;
    logic [PW-1:0] partial;
    logic          hi;
    logic          hi_next;
    logic          done;
    logic          done_next;

    // Sum of the shifted multiplicand copies selected by the low multiplier bits.
    always_comb begin
        partial = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (s2[i]) begin
                partial = partial + (s1 << i);
            end
        end
    end

    always_comb begin
        state_next = state;
        acc_next   = acc;
        s1_next    = s1;
        s2_next    = s2;
        hi_next    = hi;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (I_en) begin
                    acc_next   = '0;
                    s1_next    = I_s1_signed ? {{WIDTH{I_s1[WIDTH-1]}}, I_s1}
                                             : {{WIDTH{1'b0}}, I_s1};
                    // Sign-extending the multiplier only matters for the upper half.
                    s2_next    = (I_s2_signed && I_hi) ? {{WIDTH{I_s2[WIDTH-1]}}, I_s2}
                                                       : {{WIDTH{1'b0}}, I_s2};
                    hi_next    = I_hi;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (s2 == '0) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    acc_next = acc + partial;
                    s1_next  = s1 << BITS_PER_CYCLE;
                    s2_next  = s2 >> BITS_PER_CYCLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (!I_reset_n) begin
            state <= IDLE;
            acc   <= '0;
            s1    <= '0;
            s2    <= '0;
            hi    <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            s1    <= s1_next;
            s2    <= s2_next;
            hi    <= hi_next;
            done  <= done_next;
        end
    end

    assign O_result  = hi ? acc[PW-1:WIDTH] : acc[WIDTH-1:0];
    assign O_product = acc;
    assign O_busy    = (state == RUN);
    assign O_done    = done;

endmodule

// File: doc/spu32_cpu_mul_radix.md
SPU32_CPU_MUL_RADIX -- requirements
Module: spu32_cpu_mul_radix

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have parameter BITS_PER_CYCLE, default 2, multiplier bits retired per cycle; legal values 1, 2, 4, 8; WIDTH SHALL be a multiple of it.
REQ-003 SHALL have port I_clk, input, 1: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port I_reset_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port I_en, input, 1: start request; sampled only when idle.
REQ-006 SHALL have ports I_s1 and I_s2, input, WIDTH: multiplicand and multiplier.
REQ-007 SHALL have ports I_s1_signed and I_s2_signed, input, 1: operand signedness.
REQ-008 SHALL have port I_hi, input, 1: select upper half of the product.
REQ-009 SHALL have port O_result, output, WIDTH: selected product half.
REQ-010 SHALL have port O_product, output, 2*WIDTH: full accumulator.
REQ-011 SHALL have port O_busy, output, 1: operation in progress.
REQ-012 SHALL have port O_done, output, 1: one-cycle completion pulse.

Function
REQ-013 SHALL have two states, IDLE (O_busy=0) and RUN (O_busy=1).
REQ-014 In IDLE with I_en=1: accumulator cleared; s1 loaded as I_s1 extended to 2*WIDTH (sign-extended iff I_s1_signed); s2 loaded as I_s2 extended to 2*WIDTH, sign-extended only if I_s2_signed AND I_hi, else zero-extended; I_hi latched; enter RUN.
REQ-015 In IDLE with I_en=0: all state held.
REQ-016 In RUN, per edge with s2 != 0: accumulator += sum over i<BITS_PER_CYCLE of (s2[i] ? s1<<i : 0), modulo 2^(2*WIDTH); s1 shifted left by BITS_PER_CYCLE; s2 shifted right logically by BITS_PER_CYCLE.
REQ-017 In RUN, on the edge with s2 == 0: return to IDLE, O_done=1 for exactly that following cycle, accumulator held.
REQ-018 Early termination SHALL occur: iteration count = ceil(index of highest set bit of extended s2 +1 / BITS_PER_CYCLE); s2=0 gives zero iterations.
REQ-019 Busy cycles SHALL be iterations+1; worst case WIDTH/BITS_PER_CYCLE+1 for low or unsigned-multiplier ops, 2*WIDTH/BITS_PER_CYCLE+1 for signed-multiplier high ops.
REQ-020 I_en and operand inputs SHALL be ignored while RUN; no queuing.
REQ-021 I_en asserted in the O_done cycle SHALL start a new operation (back-to-back, no dead cycle).
REQ-022 O_result SHALL be accumulator[2*WIDTH-1:WIDTH] if latched hi=1, else accumulator[WIDTH-1:0]; combinational from registers.
REQ-023 O_result/O_product SHALL remain stable from O_done until the next accepted start.
REQ-024 Low half SHALL be correct for all signedness combinations; high half SHALL equal RISC-V MULH, MULHU, MULHSU for (s,s), (u,u), (s,u); (u,s) high half is unspecified.

Reset
REQ-025 With I_reset_n=0 at an edge: state IDLE, O_busy=0, O_done=0, accumulator=0, latched hi=0; reset overrides I_en and any in-progress operation.
REQ-026 After reset, O_result=0, O_product=0 until first completion.
REQ-027 Operation aborted by reset SHALL NOT produce O_done.

Verification
REQ-028 WIDTH=32, K=2: I_s1=7, I_s2=6, unsigned, hi=0 -> O_done 3 cycles after start edge, O_result=42.
REQ-029 WIDTH=32, K=2: 0xFFFFFFFF x 0xFFFFFFFF unsigned hi=1 -> O_result=0xFFFFFFFE, O_product=0xFFFFFFFE00000001, 17 busy cycles.
REQ-030 Signed x signed hi=1: 0xFFFFFFFF x 0xFFFFFFFF -> O_result=0x00000000; signed x unsigned hi=1: 0xFFFFFFFF x 2 -> O_result=0xFFFFFFFF.
REQ-031 I_s2=0, any mode -> O_busy for 1 cycle, O_done next, O_result=0; back-to-back start in O_done cycle accepted.
REQ-032 I_reset_n=0 at 2nd RUN cycle of 0x1234x0x5678 -> next cycle O_busy=0, O_done=0, O_product=0; no later O_done.
REQ-033 Parameter sweep K in {1,2,4,8}, WIDTH in {16,32}: random operands, all four modes, compared against reference product; cycle counts match REQ-019.
